// File: rtl/calc_operand_entry_if.sv
// Button/switch inputs and registered operand outputs shared between
// the operand-entry front end and whatever drives or observes it.
interface calc_operand_entry_if;
    logic       enter_n;
    logic       op_n;
    logic [3:0] sw;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [1:0] op_sel;
    logic       valid;
    logic [1:0] state_out;

    modport master (
        output enter_n, op_n, sw,
        input  a_out, b_out, op_sel, valid, state_out
    );

    modport slave (
        input  enter_n, op_n, sw,
        output a_out, b_out, op_sel, valid, state_out
    );
endinterface

// File: rtl/calc_operand_entry.sv
// Operand entry front end: synchronizes and debounces the enter/op buttons and
// collects operands A and B into registers for the calculator datapath.
module calc_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    calc_operand_entry_if.slave  bus
);
    localparam logic [1:0] ST_GET_A = 2'b00;
    localparam logic [1:0] ST_GET_B = 2'b01;
    localparam logic [1:0] ST_SHOW  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Bit 0 = enter button, bit 1 = op button.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       level_q, level_d;
    logic [1:0]       prev_q;
    logic [1:0]       arm_q, arm_d;
    logic [1:0]       pulse_q, pulse_d;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic             enter_pulse_s, op_pulse_s;
    logic [1:0]       state_q, state_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             valid_q, valid_d;

    assign raw_s = {bus.op_n, bus.enter_n};

    // Debounce next-state; a button is armed only once a genuine released
    // sample has passed the synchronizer, so a button held through reset
    // produces no pulse until it is released and pressed again.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = cnt_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = {CNT_W{1'b0}};
                end else begin
                    cnt_d[i]   = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = {CNT_W{1'b0}};
            end
            arm_d[i]   = arm_q[i] | (fill_q[1] & sync2_q[i]);
            pulse_d[i] = arm_q[i] & prev_q[i] & ~level_q[i];
        end
    end

    // Synchronizer, debounce and press-pulse registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            level_q  <= 2'b11;
            prev_q   <= 2'b11;
            arm_q    <= 2'b00;
            pulse_q  <= 2'b00;
            fill_q   <= 2'b00;
            cnt_q[0] <= {CNT_W{1'b0}};
            cnt_q[1] <= {CNT_W{1'b0}};
        end else begin
            sync1_q  <= raw_s;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            prev_q   <= level_q;
            arm_q    <= arm_d;
            pulse_q  <= pulse_d;
            fill_q   <= {fill_q[0], 1'b1};
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign enter_pulse_s = pulse_q[0];
    assign op_pulse_s    = pulse_q[1];

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the unused encoding falls back to GET_A.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GET_A: begin
                if (enter_pulse_s) state_d = ST_GET_B;
                else               state_d = ST_GET_A;
            end
            ST_GET_B: begin
                if (enter_pulse_s) state_d = ST_SHOW;
                else               state_d = ST_GET_B;
            end
            ST_SHOW: begin
                if (enter_pulse_s) state_d = ST_GET_A;
                else               state_d = ST_SHOW;
            end
            default: state_d = ST_GET_A;
        endcase
    end

    // Output next-values: operand capture, op rotation, valid from next state.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        if (enter_pulse_s) begin
            case (state_q)
                ST_GET_A: a_d = bus.sw;
                ST_GET_B: b_d = bus.sw;
                default:  a_d = a_q;
            endcase
        end else begin
            a_d = a_q;
        end
        if (op_pulse_s) begin
            case (op_q)
                2'b00:   op_d = 2'b01;
                2'b01:   op_d = 2'b10;
                default: op_d = 2'b00;
            endcase
        end else begin
            op_d = op_q;
        end
        valid_d = (state_d == ST_SHOW);
    end

    // Registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            op_q    <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.op_sel    = op_q;
    assign bus.valid     = valid_q;
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry with a short debounce window (4 cycles);
// a press becomes visible on the outputs exactly 8 clock edges after the fall.
module tb_calc_operand_entry;
    logic CLOCK_50;
    logic resetn;
    int   n_checks;
    int   n_fail;

    calc_operand_entry_if bus ();

    calc_operand_entry #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] op, input logic v, input logic [1:0] st);
        chk({tag, ".a"},     {4'h0, bus.a_out},     {4'h0, a});
        chk({tag, ".b"},     {4'h0, bus.b_out},     {4'h0, b});
        chk({tag, ".op"},    {6'h0, bus.op_sel},    {6'h0, op});
        chk({tag, ".valid"}, {7'h0, bus.valid},     {7'h0, v});
        chk({tag, ".state"}, {6'h0, bus.state_out}, {6'h0, st});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with enter held down.
        resetn      = 1'b0;
        bus.enter_n = 1'b0;
        bus.op_n    = 1'b1;
        bus.sw      = 4'h0;
        tick(3);
        chk_outs("reset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
        resetn = 1'b1;
        tick(12);
        chk_outs("held_thru_reset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
        bus.enter_n = 1'b1;
        tick(10);
        chk("after_release.state", {6'h0, bus.state_out}, 8'h00);

        // Basic entry, with exact latency boundary on the first press.
        bus.sw = 4'h5;
        bus.enter_n = 1'b0;
        tick(7);
        chk_outs("latency_minus1", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
        tick(1);
        chk_outs("enter_a", 4'h5, 4'h0, 2'b00, 1'b0, 2'b01);
        bus.enter_n = 1'b1;
        tick(8);
        bus.sw = 4'hC;
        bus.enter_n = 1'b0;
        tick(8);
        chk_outs("enter_b", 4'h5, 4'hC, 2'b00, 1'b1, 2'b10);
        bus.enter_n = 1'b1;
        tick(8);
        bus.sw = 4'h3;
        bus.enter_n = 1'b0;
        tick(8);
        chk_outs("show_exit", 4'h5, 4'hC, 2'b00, 1'b0, 2'b00);
        bus.enter_n = 1'b1;
        tick(8);

        // Bounce shorter than the window is rejected.
        for (int i = 0; i < 6; i++) begin
            bus.enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        bus.enter_n = 1'b1;
        tick(8);
        chk_outs("bounce", 4'h5, 4'hC, 2'b00, 1'b0, 2'b00);
        bus.sw = 4'h7;
        bus.enter_n = 1'b0;
        tick(10);
        chk_outs("long_hold", 4'h7, 4'hC, 2'b00, 1'b0, 2'b01);
        tick(10);
        chk("still_one_pulse.state", {6'h0, bus.state_out}, 8'h01);
        bus.enter_n = 1'b1;
        tick(8);

        // Into SHOW, then rotate op_sel four times.
        bus.sw = 4'h2;
        bus.enter_n = 1'b0;
        tick(8);
        chk_outs("show_b2", 4'h7, 4'h2, 2'b00, 1'b1, 2'b10);
        bus.enter_n = 1'b1;
        tick(8);
        bus.op_n = 1'b0; tick(8);
        chk_outs("op1", 4'h7, 4'h2, 2'b01, 1'b1, 2'b10);
        bus.op_n = 1'b1; tick(8);
        bus.op_n = 1'b0; tick(8);
        chk_outs("op2", 4'h7, 4'h2, 2'b10, 1'b1, 2'b10);
        bus.op_n = 1'b1; tick(8);
        bus.op_n = 1'b0; tick(8);
        chk_outs("op3", 4'h7, 4'h2, 2'b00, 1'b1, 2'b10);
        bus.op_n = 1'b1; tick(8);
        bus.op_n = 1'b0; tick(8);
        chk_outs("op4", 4'h7, 4'h2, 2'b01, 1'b1, 2'b10);
        bus.op_n = 1'b1; tick(8);

        // Back to GET_A, enter A=4, then simultaneous enter+op in GET_B.
        bus.enter_n = 1'b0; tick(8);
        chk_outs("to_get_a", 4'h7, 4'h2, 2'b01, 1'b0, 2'b00);
        bus.enter_n = 1'b1; tick(8);
        bus.sw = 4'h4;
        bus.enter_n = 1'b0; tick(8);
        bus.enter_n = 1'b1; tick(8);
        bus.sw = 4'h9;
        bus.enter_n = 1'b0;
        bus.op_n = 1'b0;
        tick(7);
        chk_outs("simul_before", 4'h4, 4'h2, 2'b01, 1'b0, 2'b01);
        tick(1);
        chk_outs("simul", 4'h4, 4'h9, 2'b10, 1'b1, 2'b10);
        bus.enter_n = 1'b1;
        bus.op_n = 1'b1;
        tick(8);

        // Reset in the middle of entry clears outputs without a clock edge.
        bus.enter_n = 1'b0; tick(8);
        bus.enter_n = 1'b1; tick(8);
        bus.sw = 4'h7;
        bus.enter_n = 1'b0; tick(8);
        bus.enter_n = 1'b1; tick(8);
        chk_outs("pre_midreset", 4'h7, 4'h9, 2'b10, 1'b0, 2'b01);
        #2;
        resetn = 1'b0;
        #1;
        chk_outs("midreset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
        tick(2);
        resetn = 1'b1;
        tick(10);
        chk_outs("post_reset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
